// File: rtl/colorled_pkg.sv
// Shared types and default parameters for the colour-LED blink controller.
package colorled_pkg;

  localparam int unsigned CLK_DIV_DEF  = 1000;
  localparam int unsigned PULSE_W_DEF  = 2;
  localparam int unsigned PERIOD_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } colorled_state_e;

  // Number of LED toggles a counted sequence performs (two per blink).
  function automatic logic [8:0] toggle_target(input logic [7:0] count);
    return {count, 1'b0};
  endfunction

endpackage

// File: rtl/colorled_tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every CLK_DIV enabled cycles.
module colorled_tick_prescaler #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic clk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Tick fires on the last cycle of each CLK_DIV window.
  assign tick = enable && !clear && (cnt == LAST);

  // Divider counter: cleared on request, wraps at CLK_DIV-1 while enabled.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/colorled_blink_ctrl.sv
// Blink sequencer for a colour LED stage that toggles on the falling edge of
// o_enable_colorled while o_syncing_colLED is held high.
//
// Request semantics: i_start and i_stop are single-cycle requests sampled on
// the rising clock edge. i_start is only accepted in IDLE; i_stop is only
// remembered while a sequence is running (or together with an accepted
// start). There is no backpressure; every accepted request is acted on.
module colorled_blink_ctrl
  import colorled_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned PULSE_W  = PULSE_W_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [7:0]          i_count,
  output logic                o_enable_colorled,
  output logic                o_syncing_colLED,
  output logic                o_led_on,
  output logic                o_busy,
  output logic                o_done,
  output colorled_state_e     state_dbg
);

  localparam int unsigned PW_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [PW_W-1:0] PULSE_LAST = PW_W'(PULSE_W - 1);

  colorled_state_e     state;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [7:0]          count_q;
  logic [8:0]          tog_cnt;
  logic [PW_W-1:0]     pulse_cnt;
  logic                stop_pending;

  logic                tick;
  logic                presc_en;
  logic                presc_clr;
  logic [8:0]          tog_next;
  logic                led_next;
  logic                target_hit;
  logic                stop_now;
  logic                pulse_last;
  logic                wait_last;

  assign state_dbg = state;

  // The prescaler only runs in WAIT, so every WAIT starts on a fresh window.
  assign presc_en  = (state == ST_WAIT);
  assign presc_clr = (state != ST_WAIT);

  colorled_tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (presc_clr),
    .enable  (presc_en),
    .tick    (tick)
  );

  // Decisions taken at the end of a strobe or wait interval.
  always_comb begin
    led_next   = ~o_led_on;
    // Continuous mode only needs parity; counted mode needs the full count.
    tog_next   = (count_q == 8'd0) ? {8'd0, ~tog_cnt[0]} : tog_cnt + 9'd1;
    target_hit = (count_q != 8'd0) && (tog_next == toggle_target(count_q));
    stop_now   = stop_pending || i_stop;
    pulse_last = (pulse_cnt == PULSE_LAST);
    wait_last  = tick && (tick_cnt == period_q - PERIOD_W'(1));
  end

  // Sequencer FSM; every output is registered and updated on the transition.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= ST_IDLE;
      period_q          <= '0;
      tick_cnt          <= '0;
      count_q           <= '0;
      tog_cnt           <= '0;
      pulse_cnt         <= '0;
      stop_pending      <= 1'b0;
      o_enable_colorled <= 1'b0;
      o_syncing_colLED  <= 1'b0;
      o_led_on          <= 1'b0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (o_busy && i_stop) begin
        stop_pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            period_q         <= (i_period == '0) ? PERIOD_W'(1) : i_period;
            count_q          <= i_count;
            tog_cnt          <= '0;
            tick_cnt         <= '0;
            // A stop arriving with the start limits the run to one blink.
            stop_pending     <= i_stop;
            o_syncing_colLED <= 1'b1;
            o_busy           <= 1'b1;
            state            <= ST_ARM;
          end
        end

        ST_ARM: begin
          pulse_cnt         <= '0;
          o_enable_colorled <= 1'b1;
          state             <= ST_STROBE;
        end

        ST_STROBE: begin
          if (pulse_last) begin
            o_enable_colorled <= 1'b0;
            o_led_on          <= led_next;
            tog_cnt           <= tog_next;
            if (target_hit || (stop_now && !led_next)) begin
              state <= ST_HOLD;
            end else begin
              tick_cnt <= '0;
              state    <= ST_WAIT;
            end
          end else begin
            pulse_cnt <= pulse_cnt + PW_W'(1);
          end
        end

        ST_WAIT: begin
          if (stop_now) begin
            // Abort the wait; an extra strobe is needed only if the LED is lit.
            if (o_led_on) begin
              pulse_cnt         <= '0;
              o_enable_colorled <= 1'b1;
              state             <= ST_STROBE;
            end else begin
              state <= ST_HOLD;
            end
          end else if (tick) begin
            if (wait_last) begin
              pulse_cnt         <= '0;
              o_enable_colorled <= 1'b1;
              state             <= ST_STROBE;
            end else begin
              tick_cnt <= tick_cnt + PERIOD_W'(1);
            end
          end
        end

        ST_HOLD: begin
          stop_pending     <= 1'b0;
          o_syncing_colLED <= 1'b0;
          o_busy           <= 1'b0;
          o_done           <= 1'b1;
          state            <= ST_IDLE;
        end

        default: begin
          o_enable_colorled <= 1'b0;
          o_syncing_colLED  <= 1'b0;
          o_busy            <= 1'b0;
          state             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
